seg_display_capture: RTL and testbench
======================================

Name: seg_display_capture

Overview:
- Receive side of the multiplexed 8-digit seven-segment bus (AN/C) driven by the display tracker path.
- Samples the scanned anode/cathode lines, decodes each digit slot back to a 4-bit hex value, and assembles a full 8-digit frame.
- Used for on-chip loopback self-test of the score/position display and as a synthesizable bus monitor in simulation.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a slot is accepted (legal range 2..255).
- ANODE_ACTIVE_LOW, 1, 1 means an anode is selected when its AN bit is 0.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- AN  input  8  anode select lines. Exactly one bit is active per digit slot; all inactive means blank.
- C  input  8  cathodes, active-low. C[0]=a … C[6]=g, C[7]=DP.
- digits  output  32  last complete frame. digits[4k+3:4k] is the value of anode k.
- dp  output  8  last complete frame decimal points. dp[k]=1 means the DP was lit on anode k.
- frame_valid  output  1  one-cycle pulse when digits/dp update.
- err_multi  output  1  one-cycle pulse: an accepted sample had more than one anode active.
- err_seg  output  1  one-cycle pulse: an accepted sample carried a non-hex segment pattern.
- frame_count  output  16  number of completed frames, wrapping.

Behaviour:
- Input stage: AN and C are registered once (an_q, c_q). All logic operates on the registered values.
- Normalisation: sel = ANODE_ACTIVE_LOW ? ~an_q : an_q. seg = ~c_q[6:0], giving active-high gfedcba.
- Stability counter cnt (8 bit):
  - Reset to 0 when {an_q,c_q} differs from the previous registered sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  - BLANK: sel==0. No capture; cnt still tracks. Leaves when sel!=0.
  - SETTLE: counting. Goes to BLANK if sel becomes 0. On the edge where cnt reaches STABLE_CYCLES-1 with an unchanged sample (STABLE_CYCLES identical samples in total), performs ACCEPT and moves to HOLD.
  - HOLD: slot already accepted. Stays until the sample changes, then goes to SETTLE (or BLANK if sel==0). At most one accept per continuous slot occurrence.
- ACCEPT rules, evaluated in priority order:
  - popcount(sel)>1: err_multi pulses; nothing is written.
  - seg not in the hex table: err_seg pulses; nothing is written.
  - Otherwise: wr_buf[k] is set to the decoded nibble, dp_buf[k] = ~c_q[7], and seen[k] is set. k is the index of the single active bit.
- Hex table (gfedcba, active-high):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Frame completion:
  - When an ACCEPT makes seen==8'hFF, on that same edge: digits/dp load the working buffer (including the digit just accepted), seen clears, and frame_count increments (wraps at 16'hFFFF→0).
  - frame_valid is high during the following cycle only.
- A repeated anode before the frame completes overwrites that wr_buf entry; it does not complete the frame.
- Total latency: 1 cycle (input register) + STABLE_CYCLES samples from the first cycle of a stable slot to the wr_buf write. frame_valid follows one cycle after the completing write.
- Reset (synchronous, any time including mid-slot):
  - Outputs: digits=0, dp=0, frame_valid=0, err_multi=0, err_seg=0, frame_count=0.
  - Internal: seen=0, wr_buf=0, cnt=0, state=BLANK, an_q=all-inactive, c_q=8'hFF.
- Simultaneous events: an error and a frame completion cannot coincide, because an erroring accept never sets seen. err pulses are mutually exclusive.

Test Plan:
- Reset then idle with AN=FF, C=FF for 100 cycles → BLANK held; all outputs 0; no pulses.
- Scan anodes 0..7 with AN=~(1<<k), 8 cycles each, C=~{0,tbl[k]} → exactly one frame_valid pulse; digits=32'h76543210; dp=00; frame_count=1.
- Same scan but each slot held only 3 cycles with STABLE_CYCLES=4 → no accept, no frame_valid, frame_count stays 0.
- Slot with AN=8'hFC (two anodes) held 10 cycles → one err_multi pulse; seen unchanged; no frame.
- Slot 2 showing C=~8'h00 (blank pattern) → one err_seg pulse; frame completes only after slot 2 later shows a valid digit.
- Assert rst for 1 cycle after anodes 0..5 are accepted, then do a full scan of "89ABCDEF" → frame_count=1; digits=32'hFEDCBA98, with no residue from the pre-reset digits.

Source files
------------

// File: rtl/seg_display_capture.sv
// Purpose : receive side of the multiplexed 8-digit seven-segment bus; decodes scanned slots into a frame.
// Latency : 1 cycle input register + STABLE_CYCLES samples to slot write; frame_valid one cycle after completing write.
// Backpres: none -- passive monitor, every cycle is sampled, outputs are pulses/levels with no ready handshake.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   AN[7:0]         anode selects (polarity set by ANODE_ACTIVE_LOW), one active per slot, none = blank
//   C[7:0]          active-low cathodes, C[0]=a .. C[6]=g, C[7]=DP
//   digits[31:0]    last complete frame, nibble k belongs to anode k
//   dp[7:0]         last complete frame decimal points, 1 = lit
//   frame_valid     one-cycle pulse after digits/dp load
//   err_multi       one-cycle pulse: accepted sample had several anodes active
//   err_seg         one-cycle pulse: accepted sample was not a hex glyph
//   frame_count     completed frames, wrapping
module seg_display_capture #(
    parameter int STABLE_CYCLES    = 4,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  AN,
    input  logic [7:0]  C,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic        frame_valid,
    output logic        err_multi,
    output logic        err_seg,
    output logic [15:0] frame_count
);

    // Idle level of the anode bus, used as the reset value of the input stage.
    localparam logic [7:0] AN_IDLE = ANODE_ACTIVE_LOW ? 8'hFF : 8'h00;
    // Stability counter saturates here.
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    // cnt holds (identical samples - 2) while a sample is stable, so the
    // STABLE_CYCLES-th identical sample is present when cnt == STABLE_CYCLES-2.
    localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Input stage and previous-sample copy used for change detection.
    logic [7:0]  an_q;
    logic [7:0]  c_q;
    logic [7:0]  an_p;
    logic [7:0]  c_p;

    logic [7:0]  cnt;
    state_t      state;
    state_t      state_nxt;

    logic [7:0]  seen;
    logic [31:0] wr_buf;
    logic [7:0]  dp_buf;

    // Normalised views of the registered sample.
    logic [7:0]  sel;
    logic [6:0]  seg;
    logic        changed;
    logic        sel_multi;
    logic [2:0]  slot;
    logic [7:0]  slot_onehot;
    logic        seg_ok;
    logic [3:0]  seg_nib;
    logic        accept;
    logic [31:0] wr_nxt;
    logic [7:0]  dp_nxt;
    logic [7:0]  seen_nxt;

    // Returns {valid, nibble} for an active-high gfedcba pattern.
    function automatic logic [4:0] hex_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Input register and previous-sample register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q <= AN_IDLE;
            c_q  <= 8'hFF;
            an_p <= AN_IDLE;
            c_p  <= 8'hFF;
        end else begin
            an_q <= AN;
            c_q  <= C;
            an_p <= an_q;
            c_p  <= c_q;
        end
    end

    // ------------------------------------------------------------------
    // Sample decode
    // ------------------------------------------------------------------
    always_comb begin
        sel       = ANODE_ACTIVE_LOW ? ~an_q : an_q;
        seg       = ~c_q[6:0];
        changed   = ({an_q, c_q} != {an_p, c_p});
        sel_multi = ($countones(sel) > 1);
        {seg_ok, seg_nib} = hex_decode(seg);
    end

    // Index of the active anode; only meaningful when exactly one bit is set.
    always_comb begin
        slot = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (sel[i]) begin
                slot = 3'(i);
            end
        end
        slot_onehot = 8'd1 << slot;
    end

    // Working buffers as they would look after writing the current slot;
    // the frame load uses these so the completing digit is included.
    always_comb begin
        wr_nxt                    = wr_buf;
        wr_nxt[{slot, 2'b00} +: 4] = seg_nib;
        dp_nxt                    = dp_buf;
        dp_nxt[slot]              = ~c_q[7];
        seen_nxt                  = seen | slot_onehot;
    end

    // ------------------------------------------------------------------
    // Stability counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (changed) begin
            cnt <= 8'd0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Slot FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            BLANK: begin
                if (sel != 8'd0) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (sel == 8'd0) begin
                    state_nxt = BLANK;
                end else if (!changed && (cnt >= CNT_ACC)) begin
                    // >= rather than == so a slot can never be stranded in
                    // SETTLE if cnt were already past the threshold.
                    accept    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (sel == 8'd0) begin
                    state_nxt = BLANK;
                end else if (changed) begin
                    state_nxt = SETTLE;
                end
            end
            default: begin
                state_nxt = BLANK;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accept: error checks, buffer write, frame completion
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            seen        <= 8'd0;
            wr_buf      <= 32'd0;
            dp_buf      <= 8'd0;
            digits      <= 32'd0;
            dp          <= 8'd0;
            frame_valid <= 1'b0;
            err_multi   <= 1'b0;
            err_seg     <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            frame_valid <= 1'b0;
            err_multi   <= 1'b0;
            err_seg     <= 1'b0;
            if (accept) begin
                if (sel_multi) begin
                    err_multi <= 1'b1;
                end else if (!seg_ok) begin
                    err_seg <= 1'b1;
                end else begin
                    wr_buf <= wr_nxt;
                    dp_buf <= dp_nxt;
                    if (seen_nxt == 8'hFF) begin
                        digits      <= wr_nxt;
                        dp          <= dp_nxt;
                        seen        <= 8'd0;
                        frame_count <= frame_count + 16'd1;
                        frame_valid <= 1'b1;
                    end else begin
                        seen <= seen_nxt;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_display_capture.sv
module tb_seg_display_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  AN;
    logic [7:0]  C;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic        frame_valid;
    logic        err_multi;
    logic        err_seg;
    logic [15:0] frame_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int fv_cnt = 0;
    int em_cnt = 0;
    int es_cnt = 0;
    int fv0, em0, es0;

    seg_display_capture #(
        .STABLE_CYCLES    (4),
        .ANODE_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .AN          (AN),
        .C           (C),
        .digits      (digits),
        .dp          (dp),
        .frame_valid (frame_valid),
        .err_multi   (err_multi),
        .err_seg     (err_seg),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    // Pulse monitors: count every cycle each pulse output is high.
    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (err_multi)   em_cnt++;
        if (err_seg)     es_cnt++;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All drivers run from a negedge and return on a negedge.
    task automatic idle(input int n);
        AN = 8'hFF;
        C  = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int k, input logic [3:0] nib, input logic dpb, input int hold);
        AN = ~(8'd1 << k);
        C  = ~{dpb, seg_of(nib)};
        repeat (hold) @(negedge clk);
    endtask

    task automatic scan(input logic [31:0] val, input logic [7:0] dpm,
                        input logic [7:0] mask, input int hold);
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) show(k, val[4*k +: 4], dpm[k], hold);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        AN  = 8'hFF;
        C   = 8'hFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic snap();
        fv0 = fv_cnt;
        em0 = em_cnt;
        es0 = es_cnt;
    endtask

    initial begin
        rst = 1'b1;
        AN  = 8'hFF;
        C   = 8'hFF;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_digits",      digits,      32'h0);
        check("rst_dp",          dp,          32'h0);
        check("rst_fv",          frame_valid, 32'h0);
        check("rst_em",          err_multi,   32'h0);
        check("rst_es",          err_seg,     32'h0);
        check("rst_fcount",      frame_count, 32'h0);
        rst = 1'b0;

        // Idle bus for 100 cycles: nothing happens
        snap();
        idle(100);
        check("idle_fv_pulses",  fv_cnt - fv0, 32'd0);
        check("idle_em_pulses",  em_cnt - em0, 32'd0);
        check("idle_es_pulses",  es_cnt - es0, 32'd0);
        check("idle_digits",     digits,       32'h0);
        check("idle_fcount",     frame_count,  32'h0);

        // Full scan, 8 cycles per slot, with exact latency of the final slot
        snap();
        scan(32'h76543210, 8'h00, 8'h7F, 8);
        show(7, 4'h7, 1'b0, 4);
        check("lat_fv_early",    frame_valid, 32'h0);
        @(negedge clk);
        check("lat_fv_on_time",  frame_valid, 32'h1);
        check("lat_digits",      digits,      32'h76543210);
        @(negedge clk);
        check("lat_fv_width",    frame_valid, 32'h0);
        idle(6);
        check("scan_fv_pulses",  fv_cnt - fv0, 32'd1);
        check("scan_digits",     digits,       32'h76543210);
        check("scan_dp",         dp,           32'h00);
        check("scan_fcount",     frame_count,  32'd1);
        check("scan_err_pulses", (em_cnt - em0) + (es_cnt - es0), 32'd0);

        // Slots held 3 cycles: one short of the threshold, nothing accepted
        do_reset();
        snap();
        scan(32'h76543210, 8'h00, 8'hFF, 3);
        idle(6);
        check("short_fv_pulses", fv_cnt - fv0, 32'd0);
        check("short_fcount",    frame_count,  32'd0);
        check("short_digits",    digits,       32'h0);

        // Two anodes at once: err_multi, and anodes 0/1 must not be marked seen
        do_reset();
        snap();
        AN = 8'hFC;
        C  = ~{1'b0, seg_of(4'h5)};
        repeat (10) @(negedge clk);
        idle(4);
        check("multi_em_pulses", em_cnt - em0, 32'd1);
        check("multi_es_pulses", es_cnt - es0, 32'd0);
        check("multi_fv_pulses", fv_cnt - fv0, 32'd0);
        scan(32'h76543210, 8'h00, 8'hFC, 8);
        idle(6);
        check("multi_no_frame",  fv_cnt - fv0, 32'd0);
        scan(32'h76543210, 8'h00, 8'h03, 8);
        idle(6);
        check("multi_fv_later",  fv_cnt - fv0, 32'd1);
        check("multi_digits",    digits,       32'h76543210);
        check("multi_fcount",    frame_count,  32'd1);

        // Blank pattern on slot 2: err_seg, frame waits for a valid slot 2
        do_reset();
        snap();
        scan(32'hC0FFEE42, 8'h81, 8'h03, 8);
        AN = 8'hFB;
        C  = 8'hFF;
        repeat (8) @(negedge clk);
        scan(32'hC0FFEE42, 8'h81, 8'hF8, 8);
        idle(6);
        check("seg_es_pulses",   es_cnt - es0, 32'd1);
        check("seg_em_pulses",   em_cnt - em0, 32'd0);
        check("seg_no_frame",    fv_cnt - fv0, 32'd0);
        scan(32'hC0FFEE42, 8'h81, 8'h04, 8);
        idle(6);
        check("seg_fv_later",    fv_cnt - fv0, 32'd1);
        check("seg_digits",      digits,       32'hC0FFEE42);
        check("seg_dp",          dp,           32'h81);
        check("seg_fcount",      frame_count,  32'd1);

        // Reset after a partial frame, then a full scan held exactly 4 cycles
        scan(32'h01234567, 8'h00, 8'h3F, 8);
        rst = 1'b1;
        AN  = 8'hFF;
        C   = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_digits",  digits,      32'h0);
        check("mid_rst_dp",      dp,          32'h0);
        check("mid_rst_fcount",  frame_count, 32'h0);
        snap();
        scan(32'hFEDCBA98, 8'h00, 8'hC0, 4);
        idle(6);
        check("mid_rst_seen",    fv_cnt - fv0, 32'd0);
        scan(32'hFEDCBA98, 8'h00, 8'h3F, 4);
        idle(6);
        check("post_fv_pulses",  fv_cnt - fv0, 32'd1);
        check("post_digits",     digits,       32'hFEDCBA98);
        check("post_dp",         dp,           32'h00);
        check("post_fcount",     frame_count,  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
